// File: rtl/life_sequencer_pkg.sv
// Shared definitions for the life torus, seed loader and generation sequencer.
package life_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_PACE = 2'd2
  } state_t;

  localparam int GEN_W = 16;

endpackage

// File: rtl/life_sequencer_frame_pacer.sv
// Vsync falling-edge detector plus frame pacing; gen_tick marks the cycle a generation is due.
module life_sequencer_frame_pacer #(
  parameter int SPEED_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active,
  input  logic               vsync,
  input  logic               run,
  input  logic               step_req,
  input  logic [SPEED_W-1:0] speed,
  output logic               gen_tick
);

  logic               vsync_q;
  logic [SPEED_W-1:0] frame_cnt;
  logic               pending;
  logic               frame_tick;

  assign frame_tick = vsync_q & ~vsync;

  // The >= compare lets a speed lowered below the running count fire on the next tick.
  always_comb begin
    gen_tick = 1'b0;
    if (active && frame_tick) begin
      gen_tick = run ? (frame_cnt >= speed) : pending;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q   <= 1'b1;
      frame_cnt <= '0;
      pending   <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (!active) begin
        frame_cnt <= '0;
        pending   <= 1'b0;
      end else if (run) begin
        pending <= 1'b0;
        if (frame_tick) begin
          if (frame_cnt >= speed) frame_cnt <= '0;
          else                    frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        frame_cnt <= '0;
        // Any number of requests before a tick collapse into one step.
        pending   <= (pending & ~frame_tick) | step_req;
      end
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Generation sequencer: loads the torus from a bit source, then paces life steps off vsync.
module life_sequencer
  import life_sequencer_pkg::*;
#(
  parameter int TORUS_WIDTH  = 32,
  parameter int TORUS_HEIGHT = 32,
  parameter int SPEED_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               run,
  input  logic               step_req,
  input  logic [SPEED_W-1:0] speed,
  input  logic               seed_req,
  input  logic               seed_src_bit,
  output logic               seed_src_rd,
  output logic               seed,
  output logic               seed_ena,
  output logic               life_step,
  output logic               busy,
  output logic [GEN_W-1:0]   gen_count,
  output state_t             state
);

  localparam int N     = TORUS_WIDTH * TORUS_HEIGHT;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(N - 1);

  logic [CNT_W-1:0] cell_cnt;
  logic             pacer_active;
  logic             gen_tick;

  // A pending seed_req blocks the pacer so a coincident tick never becomes a step.
  assign pacer_active = (state == ST_PACE) && !seed_req;

  life_sequencer_frame_pacer #(
    .SPEED_W (SPEED_W)
  ) u_frame_pacer (
    .clk      (clk),
    .reset    (reset),
    .active   (pacer_active),
    .vsync    (vsync),
    .run      (run),
    .step_req (step_req),
    .speed    (speed),
    .gen_tick (gen_tick)
  );

  // Seed source handshake: seed_src_bit is taken in every cycle seed_src_rd is high,
  // and reappears on seed one cycle later qualified by seed_ena.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cell_cnt    <= '0;
      seed_src_rd <= 1'b0;
      seed        <= 1'b0;
      seed_ena    <= 1'b0;
      life_step   <= 1'b0;
      busy        <= 1'b0;
      gen_count   <= '0;
    end else begin
      seed      <= seed_src_rd & seed_src_bit;
      seed_ena  <= seed_src_rd;
      life_step <= 1'b0;
      if (life_step) gen_count <= gen_count + 1'b1;

      case (state)
        ST_IDLE: begin
          if (seed_req) begin
            state       <= ST_SEED;
            cell_cnt    <= '0;
            seed_src_rd <= 1'b1;
            busy        <= 1'b1;
            gen_count   <= '0;
          end
        end
        ST_SEED: begin
          if (cell_cnt == LAST_CELL) begin
            state       <= ST_PACE;
            seed_src_rd <= 1'b0;
            busy        <= 1'b0;
          end else begin
            cell_cnt <= cell_cnt + 1'b1;
          end
        end
        ST_PACE: begin
          if (seed_req) begin
            state       <= ST_SEED;
            cell_cnt    <= '0;
            seed_src_rd <= 1'b1;
            busy        <= 1'b1;
            gen_count   <= '0;
          end else begin
            life_step <= gen_tick;
          end
        end
        default: begin
          state       <= ST_IDLE;
          seed_src_rd <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer on a 4x4 torus.
module tb_life_sequencer;
  import life_sequencer_pkg::*;

  localparam int TW = 4;
  localparam int TH = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          run;
  logic          step_req;
  logic [SW-1:0] speed;
  logic          seed_req;
  logic          seed_src_bit;
  logic          seed_src_rd;
  logic          seed;
  logic          seed_ena;
  logic          life_step;
  logic          busy;
  logic [15:0]   gen_count;
  state_t        state;

  int n_checks = 0;
  int n_errors = 0;

  life_sequencer #(
    .TORUS_WIDTH  (TW),
    .TORUS_HEIGHT (TH),
    .SPEED_W      (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .run          (run),
    .step_req     (step_req),
    .speed        (speed),
    .seed_req     (seed_req),
    .seed_src_bit (seed_src_bit),
    .seed_src_rd  (seed_src_rd),
    .seed         (seed),
    .seed_ena     (seed_ena),
    .life_step    (life_step),
    .busy         (busy),
    .gen_count    (gen_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One vsync low cycle; reports whether life_step followed that tick.
  task automatic frame(output logic fired);
    vsync = 1'b0;
    cyc();
    fired = life_step;
    vsync = 1'b1;
    cyc();
    check("life_step_one_cycle", 32'(life_step), 32'd0);
    cyc();
    cyc();
  endtask

  initial begin
    logic        f;
    logic [15:0] pat;
    pat = 16'hA5C3;

    reset = 1'b1; vsync = 1'b1; run = 1'b0; step_req = 1'b0;
    speed = '0; seed_req = 1'b0; seed_src_bit = 1'b0;
    repeat (3) cyc();
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_rd", 32'(seed_src_rd), 32'd0);
    check("rst_ena", 32'(seed_ena), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_step", 32'(life_step), 32'd0);
    check("rst_gen", 32'(gen_count), 32'd0);
    reset = 1'b0;
    cyc();
    frame(f);
    check("idle_no_step", 32'(f), 32'd0);

    // Full 4x4 load
    seed_req = 1'b1;
    cyc();
    seed_req = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      check("seed_src_rd", 32'(seed_src_rd), 32'(c <= 16));
      check("busy", 32'(busy), 32'(c <= 16));
      check("seed_ena", 32'(seed_ena), 32'(c >= 2 && c <= 17));
      check("seed_no_step", 32'(life_step), 32'd0);
      if (c >= 2 && c <= 17) check("seed_bit", 32'(seed), 32'(pat[c-2]));
      seed_src_bit = (c <= 16) ? pat[c-1] : 1'b0;
      cyc();
    end
    check("load_state", 32'(state), 32'(ST_PACE));
    check("load_gen", 32'(gen_count), 32'd0);

    // Free run, speed 2: steps on ticks 3, 6, 9
    run = 1'b1; speed = 4'd2;
    cyc();
    for (int k = 1; k <= 9; k++) begin
      frame(f);
      check("run_speed2", 32'(f), 32'(k % 3 == 0));
    end
    check("gen_after_9", 32'(gen_count), 32'd3);

    // Speed lowered below the running count fires on the next tick
    speed = 4'd5;
    for (int k = 1; k <= 3; k++) begin
      frame(f);
      check("run_speed5", 32'(f), 32'd0);
    end
    speed = 4'd1;
    frame(f);
    check("speed_lowered", 32'(f), 32'd1);
    check("gen_after_lower", 32'(gen_count), 32'd4);

    // Paused: three requests collapse into one step
    run = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1; cyc();
      step_req = 1'b0; cyc();
    end
    frame(f);
    check("step_once", 32'(f), 32'd1);
    frame(f);
    check("step_none1", 32'(f), 32'd0);
    frame(f);
    check("step_none2", 32'(f), 32'd0);
    check("gen_after_step", 32'(gen_count), 32'd5);

    // Going to run clears a pending step
    step_req = 1'b1; cyc();
    step_req = 1'b0; run = 1'b1; speed = 4'd15; cyc();
    run = 1'b0; cyc();
    frame(f);
    check("pending_cleared", 32'(f), 32'd0);
    check("gen_unchanged", 32'(gen_count), 32'd5);

    // seed_req wins over a coincident qualifying tick
    run = 1'b1; speed = 4'd0;
    cyc();
    frame(f);
    check("speed0_fires", 32'(f), 32'd1);
    check("gen_before_seed", 32'(gen_count), 32'd6);
    vsync = 1'b0; seed_req = 1'b1;
    cyc();
    vsync = 1'b1; seed_req = 1'b0;
    check("prio_no_step", 32'(life_step), 32'd0);
    check("prio_busy", 32'(busy), 32'd1);
    check("prio_state", 32'(state), 32'(ST_SEED));
    check("prio_gen", 32'(gen_count), 32'd0);

    // Reset while loading cell 7
    repeat (7) cyc();
    check("cell7_ena", 32'(seed_ena), 32'd1);
    check("cell7_rd", 32'(seed_src_rd), 32'd1);
    reset = 1'b1;
    cyc();
    check("abort_ena", 32'(seed_ena), 32'd0);
    check("abort_rd", 32'(seed_src_rd), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(state), 32'(ST_IDLE));
    reset = 1'b0;
    cyc();
    frame(f);
    check("post_reset_no_step", 32'(f), 32'd0);
    check("post_reset_state", 32'(state), 32'(ST_IDLE));
    check("post_reset_gen", 32'(gen_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
